// File: rtl/wb_select_stage.sv
// Registered writeback stage: it captures execute results, decodes the memory region, aligns
// and extends load data, and holds read data across stalls. Optional forwarding: WB_FWD_EN.
module wb_select_stage #(
    parameter logic [3:0] DMEM_TAG  = 4'b0001,
    parameter logic [3:0] DMEM_MASK = 4'b1101,
    parameter logic [3:0] BIOS_TAG  = 4'b0100,
    parameter logic [3:0] BIOS_MASK = 4'b1111,
    parameter logic [3:0] IO_TAG    = 4'b1000,
    parameter logic [3:0] IO_MASK   = 4'b1111,
    parameter int         CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_funct3,
    input  logic [31:0]          in_addr,
    input  logic [31:0]          in_alu,
    input  logic [31:0]          in_pc,
    input  logic [4:0]           in_rd,
    input  logic                 in_regwen,
    input  logic [31:0]          dmem_rdata,
    input  logic [31:0]          bios_rdata,
    input  logic [31:0]          io_rdata,
    input  logic [4:0]           fwd_rs1,
    input  logic [4:0]           fwd_rs2,
    output logic [31:0]          wb_data,
    output logic [4:0]           wb_rd,
    output logic                 wb_we,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic                 misalign,
    output logic [CNT_WIDTH-1:0] retire_cnt
);
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_PC4  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 valid_reg;
    logic [1:0]           wb_sel_reg;
    logic [2:0]           funct3_reg;
    logic [31:0]          addr_reg;
    logic [31:0]          alu_reg;
    logic [31:0]          pc_reg;
    logic [4:0]           rd_reg;
    logic                 regwen_reg;
    logic                 held_reg;
    logic [31:0]          hold_word_reg;
    logic                 misalign_reg;
    logic [CNT_WIDTH-1:0] retire_cnt_reg;

    // Stage register: reset beats flush, flush beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            wb_sel_reg <= SEL_NONE;
            funct3_reg <= 3'b000;
            addr_reg   <= 32'h0;
            alu_reg    <= 32'h0;
            pc_reg     <= 32'h0;
            rd_reg     <= 5'd0;
            regwen_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (!stall) begin
            valid_reg  <= in_valid;
            wb_sel_reg <= in_wb_sel;
            funct3_reg <= in_funct3;
            addr_reg   <= in_addr;
            alu_reg    <= in_alu;
            pc_reg     <= in_pc;
            rd_reg     <= in_rd;
            regwen_reg <= in_regwen;
        end
    end

    logic [3:0]  tag;
    logic        hit_dmem;
    logic        hit_bios;
    logic        hit_io;
    logic [31:0] live_word;
    logic [31:0] raw_word;

    assign tag      = addr_reg[31:28];
    assign hit_dmem = ((tag & DMEM_MASK) == (DMEM_TAG & DMEM_MASK));
    assign hit_bios = ((tag & BIOS_MASK) == (BIOS_TAG & BIOS_MASK));
    assign hit_io   = ((tag & IO_MASK) == (IO_TAG & IO_MASK));

    always_comb begin
        live_word = 32'h0;
        if (hit_dmem)
            live_word = dmem_rdata;
        else if (hit_bios)
            live_word = bios_rdata;
        else if (hit_io)
            live_word = io_rdata;
    end

    // The synchronous memory only presents data for one cycle, so the first stalled
    // cycle snapshots it and the rest of the stall (plus the release cycle) replays it.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_reg      <= 1'b0;
            hold_word_reg <= 32'h0;
        end else if (flush) begin
            held_reg <= 1'b0;
        end else if (stall) begin
            if (!held_reg) begin
                hold_word_reg <= live_word;
                held_reg      <= 1'b1;
            end
        end else begin
            held_reg <= 1'b0;
        end
    end

    assign raw_word = held_reg ? hold_word_reg : live_word;

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        cur_mis;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = raw_word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = raw_word[16*gi +: 16];
        end
    endgenerate

    assign byte_sel = byte_lane[addr_reg[1:0]];
    assign half_sel = half_lane[addr_reg[1]];

    always_comb begin
        load_data = raw_word;
        case (funct3_reg)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = raw_word;
        endcase
    end

    always_comb begin
        cur_mis = 1'b0;
        case (funct3_reg)
            F3_LH, F3_LHU: cur_mis = addr_reg[0];
            F3_LW:         cur_mis = (addr_reg[1:0] != 2'b00);
            default:       cur_mis = 1'b0;
        endcase
    end

    logic mem_mis;
    assign mem_mis = (wb_sel_reg == SEL_MEM) & cur_mis;

    always_comb begin
        wb_data = 32'h0;
        case (wb_sel_reg)
            SEL_ALU: wb_data = alu_reg;
            SEL_PC4: wb_data = pc_reg + 32'd4;
            SEL_MEM: wb_data = load_data;
            default: wb_data = 32'h0;
        endcase
    end

    assign wb_rd = rd_reg;
    assign wb_we = valid_reg & regwen_reg & (rd_reg != 5'd0) & ~stall & ~mem_mis;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_reg <= 1'b0;
        else if (valid_reg & ~stall & mem_mis)
            misalign_reg <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            retire_cnt_reg <= '0;
        else if (valid_reg & ~stall & ~flush)
            retire_cnt_reg <= retire_cnt_reg + CNT_ONE;
    end

    assign misalign   = misalign_reg;
    assign retire_cnt = retire_cnt_reg;

`ifdef WB_FWD_EN
    logic [4:0] fwd_rs [2];
    logic [1:0] fwd_hits;
    logic       fwd_base;

    assign fwd_rs[0] = fwd_rs1;
    assign fwd_rs[1] = fwd_rs2;
    // Stall is deliberately ignored: the consumer takes wb_data in this same cycle.
    assign fwd_base  = valid_reg & regwen_reg & (rd_reg != 5'd0) & ~mem_mis;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_hits[gi] = fwd_base & (rd_reg == fwd_rs[gi]);
        end
    endgenerate

    assign fwd_hit1 = fwd_hits[0];
    assign fwd_hit2 = fwd_hits[1];

    logic unused_bits;
    assign unused_bits = ^addr_reg[27:2];
`else
    assign fwd_hit1 = 1'b0;
    assign fwd_hit2 = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{addr_reg[27:2], fwd_rs1, fwd_rs2};
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed cases and randomized operations,
// checked against a rule-level model of the region, load and writeback behaviour.
`timescale 1ns/1ps
module tb_wb_select_stage;
    localparam logic [3:0] DMEM_TAG  = 4'b0001;
    localparam logic [3:0] DMEM_MASK = 4'b1101;
    localparam logic [3:0] BIOS_TAG  = 4'b0100;
    localparam logic [3:0] BIOS_MASK = 4'b1111;
    localparam logic [3:0] IO_TAG    = 4'b1000;
    localparam logic [3:0] IO_MASK   = 4'b1111;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_regwen;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_alu, in_pc;
    logic [4:0]  in_rd, fwd_rs1, fwd_rs2;
    logic [31:0] dmem_rdata, bios_rdata, io_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we, fwd_hit1, fwd_hit2, misalign;
    logic [31:0] retire_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_retire = 0;
    bit exp_mis_flag = 0;

    wb_select_stage #(
        .DMEM_TAG(DMEM_TAG), .DMEM_MASK(DMEM_MASK),
        .BIOS_TAG(BIOS_TAG), .BIOS_MASK(BIOS_MASK),
        .IO_TAG(IO_TAG), .IO_MASK(IO_MASK), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_alu(in_alu), .in_pc(in_pc), .in_rd(in_rd),
        .in_regwen(in_regwen), .dmem_rdata(dmem_rdata), .bios_rdata(bios_rdata),
        .io_rdata(io_rdata), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .misalign(misalign),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // 0 = DMEM, 1 = BIOS, 2 = IO, 3 = unmapped
    function automatic int region_of(input logic [31:0] a);
        logic [3:0] t;
        t = a[31:28];
        if ((t & DMEM_MASK) == (DMEM_TAG & DMEM_MASK)) return 0;
        if ((t & BIOS_MASK) == (BIOS_TAG & BIOS_MASK)) return 1;
        if ((t & IO_MASK) == (IO_TAG & IO_MASK)) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit mis_model(input logic [2:0] f3, input logic [31:0] a);
        return ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 == 1)) || (f3 == 3'd2 && (a % 4 != 0));
    endfunction

    function automatic bit hit_model(input bit mis_kill, input bit we, input logic [4:0] rd,
                                     input logic [4:0] rs);
`ifdef WB_FWD_EN
        return we && rd != 0 && rd == rs && !mis_kill;
`else
        return 1'b0;
`endif
    endfunction

    // One instruction through the stage, optionally stalled, with the write checked on release.
    task automatic run_op(input string tag, input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] alu, input logic [31:0] pc,
                          input logic [4:0] rd, input bit we, input int nstall,
                          input bit fixed, input logic [31:0] fw,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        int          reg_id;
        logic [31:0] word, exp_data;
        bit          mis, kill, exp_we, h1, h2;
        @(negedge clk);
        in_valid = 1; in_wb_sel = sel; in_funct3 = f3; in_addr = a; in_alu = alu;
        in_pc = pc; in_rd = rd; in_regwen = we; stall = 0; flush = 0;
        @(posedge clk); #1;
        in_valid = 0; in_wb_sel = 0; in_regwen = 0;
        fwd_rs1 = rs1; fwd_rs2 = rs2;
        reg_id = region_of(a);
        if (fixed) begin
            dmem_rdata = (reg_id == 0) ? fw : 32'h1111_1111;
            bios_rdata = (reg_id == 1) ? fw : 32'h2222_2222;
            io_rdata   = (reg_id == 2) ? fw : 32'h3333_3333;
        end else begin
            dmem_rdata = $urandom; bios_rdata = $urandom; io_rdata = $urandom;
        end
        word = (reg_id == 0) ? dmem_rdata : (reg_id == 1) ? bios_rdata :
               (reg_id == 2) ? io_rdata : 32'h0;
        mis  = mis_model(f3, a);
        kill = (sel == 2'b10) && mis;
        case (sel)
            2'b01:   exp_data = alu;
            2'b11:   exp_data = pc + 32'd4;
            2'b10:   exp_data = load_model(f3, a, word);
            default: exp_data = 32'h0;
        endcase
        exp_we = we && rd != 0 && !kill;
        h1 = hit_model(kill, we, rd, rs1);
        h2 = hit_model(kill, we, rd, rs2);
        for (int s = 0; s < nstall; s++) begin
            stall = 1; #1;
            chk({tag, "/stall_we"}, 32'(wb_we), 32'h0);
            chk({tag, "/stall_data"}, wb_data, exp_data);
            chk({tag, "/stall_hit1"}, 32'(fwd_hit1), 32'(h1));
            @(posedge clk); #1;
            if (fixed) begin
                dmem_rdata = 32'hDEAD_BEEF; bios_rdata = 32'hDEAD_BEEF; io_rdata = 32'hDEAD_BEEF;
            end else begin
                dmem_rdata = $urandom; bios_rdata = $urandom; io_rdata = $urandom;
            end
        end
        stall = 0; #1;
        chk({tag, "/we"}, 32'(wb_we), 32'(exp_we));
        chk({tag, "/data"}, wb_data, exp_data);
        chk({tag, "/rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, "/hit1"}, 32'(fwd_hit1), 32'(h1));
        chk({tag, "/hit2"}, 32'(fwd_hit2), 32'(h2));
        @(posedge clk); #1;
        exp_retire++;
        if (kill) exp_mis_flag = 1;
        chk({tag, "/retire"}, retire_cnt, 32'(exp_retire));
        chk({tag, "/misalign"}, 32'(misalign), 32'(exp_mis_flag));
        chk({tag, "/bubble_we"}, 32'(wb_we), 32'h0);
        $display("op %s sel=%0d f3=%0d addr=%08h stalls=%0d exp_data=%08h exp_we=%0d",
                 tag, sel, f3, a, nstall, exp_data, exp_we);
    endtask

    logic [1:0]  r_sel;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [4:0]  r_rd, r_rs1, r_rs2;

    initial begin
        rst = 1; stall = 0; flush = 0; in_valid = 0; in_wb_sel = 0; in_funct3 = 0;
        in_addr = 0; in_alu = 0; in_pc = 0; in_rd = 0; in_regwen = 0;
        fwd_rs1 = 0; fwd_rs2 = 0; dmem_rdata = 0; bios_rdata = 0; io_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/data", wb_data, 32'h0);
        chk("reset/rd", 32'(wb_rd), 32'h0);
        chk("reset/we", 32'(wb_we), 32'h0);
        chk("reset/hit1", 32'(fwd_hit1), 32'h0);
        chk("reset/hit2", 32'(fwd_hit2), 32'h0);
        chk("reset/misalign", 32'(misalign), 32'h0);
        chk("reset/retire", retire_cnt, 32'h0);
        @(negedge clk);
        rst = 0;

        run_op("alu_rd5", 2'b01, 3'd0, 32'h0, 32'h1234_5678, 32'h0, 5'd5, 1, 0, 1, 32'h0, 5'd0, 5'd0);
        run_op("lb_dmem", 2'b10, 3'd0, 32'h1000_0003, 32'h0, 32'h0, 5'd6, 1, 0, 1, 32'h80FF_0000, 5'd0, 5'd0);
        run_op("lbu_dmem", 2'b10, 3'd4, 32'h1000_0003, 32'h0, 32'h0, 5'd6, 1, 0, 1, 32'h80FF_0000, 5'd0, 5'd0);
        run_op("lb_dmem_alias", 2'b10, 3'd0, 32'h3000_0001, 32'h0, 32'h0, 5'd9, 1, 0, 1, 32'h0000_A500, 5'd0, 5'd0);
        run_op("lw_bios_stall", 2'b10, 3'd2, 32'h4000_0000, 32'h0, 32'h0, 5'd10, 1, 3, 1, 32'h0BAD_F00D, 5'd0, 5'd0);
        run_op("lhu_io_stall", 2'b10, 3'd5, 32'h8000_0002, 32'h0, 32'h0, 5'd11, 1, 1, 1, 32'hC001_5EED, 5'd0, 5'd0);
        run_op("lh_misalign", 2'b10, 3'd1, 32'h1000_0001, 32'h0, 32'h0, 5'd12, 1, 0, 1, 32'h1234_5678, 5'd0, 5'd0);
        run_op("lw_unmapped", 2'b10, 3'd2, 32'h2000_0000, 32'h0, 32'h0, 5'd13, 1, 0, 1, 32'hFFFF_FFFF, 5'd0, 5'd0);
        run_op("jal_wrap", 2'b11, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd1, 1, 0, 1, 32'h0, 5'd0, 5'd0);
        run_op("rd0", 2'b01, 3'd0, 32'h0, 32'hCAFE_0000, 32'h0, 5'd0, 1, 0, 1, 32'h0, 5'd0, 5'd0);
        run_op("fwd_rs2", 2'b01, 3'd0, 32'h0, 32'h0000_0777, 32'h0, 5'd7, 1, 2, 1, 32'h0, 5'd3, 5'd7);

        // Flush and stall at the same edge: flush wins, nothing written or counted.
        @(negedge clk);
        in_valid = 1; in_wb_sel = 2'b01; in_alu = 32'h5555_AAAA; in_rd = 5'd7; in_regwen = 1;
        @(posedge clk); #1;
        in_valid = 0; in_regwen = 0; fwd_rs1 = 5'd1; fwd_rs2 = 5'd7; flush = 1; stall = 1; #1;
        chk("flush/pre_we", 32'(wb_we), 32'h0);
        chk("flush/pre_hit2", 32'(fwd_hit2), 32'(hit_model(0, 1, 5'd7, 5'd7)));
        @(posedge clk); #1;
        flush = 0; stall = 0; #1;
        chk("flush/we", 32'(wb_we), 32'h0);
        chk("flush/hit2", 32'(fwd_hit2), 32'h0);
        chk("flush/retire", retire_cnt, 32'(exp_retire));
        $display("op flush_stall retire=%0d", exp_retire);

        for (int i = 0; i < 40; i++) begin
            r_sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0: r_f3 = 3'd0;
                1: r_f3 = 3'd1;
                2: r_f3 = 3'd2;
                3: r_f3 = 3'd4;
                4: r_f3 = 3'd5;
                5: r_f3 = 3'd3;
                default: r_f3 = 3'd7;
            endcase
            r_addr = $urandom;
            r_rd   = 5'($urandom_range(0, 31));
            r_rs1  = ($urandom_range(0, 1) == 1) ? r_rd : 5'($urandom_range(0, 31));
            r_rs2  = ($urandom_range(0, 1) == 1) ? r_rd : 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d", i), r_sel, r_f3, r_addr, $urandom, $urandom, r_rd,
                   bit'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 32'h0, r_rs1, r_rs2);
        end

        // Reset in the middle of a stall clears everything.
        @(negedge clk);
        in_valid = 1; in_wb_sel = 2'b10; in_funct3 = 3'd2; in_addr = 32'h1000_0002;
        in_rd = 5'd4; in_regwen = 1;
        @(posedge clk); #1;
        in_valid = 0; in_regwen = 0; stall = 1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; stall = 0;
        exp_retire = 0; exp_mis_flag = 0;
        #1;
        chk("rst_stall/misalign", 32'(misalign), 32'h0);
        chk("rst_stall/retire", retire_cnt, 32'h0);
        chk("rst_stall/we", 32'(wb_we), 32'h0);
        chk("rst_stall/data", wb_data, 32'h0);
        $display("op reset_mid_stall");

        run_op("post_rst_alu", 2'b01, 3'd0, 32'h0, 32'h0000_0042, 32'h0, 5'd3, 1, 0, 1, 32'h0, 5'd0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
